// File: rtl/button_debouncer.sv
// Pushbutton debouncer with auto-repeat: a two-flop synchronizer feeds a debounce/hold FSM
// that emits one-cycle decr_pulse requests on an accepted press and at each auto-repeat interval.
module button_debouncer #(
    parameter int ACTIVE_LOW    = 1,
    parameter int CNT_W         = 25,
    parameter int DEB_CYCLES    = 500000,
    parameter int HOLD_CYCLES   = 25000000,
    parameter int REPEAT_CYCLES = 5000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic decr_pulse,
    output logic btn_state,
    output logic repeat_active
);

    localparam logic             IDLE_LVL    = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam bit               DEB_ONE     = (DEB_CYCLES == 1);

    typedef enum logic [2:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        REPEAT,
        RELEASE_WAIT
    } state_t;

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             decr_pulse_q, decr_pulse_d;
    logic             btn_state_q, btn_state_d;
    logic             repeat_active_q, repeat_active_d;
    logic             s;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q         <= IDLE_LVL;
            sync2_q         <= IDLE_LVL;
            state_q         <= IDLE;
            cnt_q           <= '0;
            decr_pulse_q    <= 1'b0;
            btn_state_q     <= 1'b0;
            repeat_active_q <= 1'b0;
        end else begin
            sync1_q         <= sync1_d;
            sync2_q         <= sync2_d;
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            decr_pulse_q    <= decr_pulse_d;
            btn_state_q     <= btn_state_d;
            repeat_active_q <= repeat_active_d;
        end
    end

    always_comb begin
        sync1_d      = btn_in;
        sync2_d      = sync1_q;
        s            = sync2_q ^ IDLE_LVL;
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_ONE;
        decr_pulse_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (s) begin
                    // A single-cycle debounce is satisfied by the sample that leaves IDLE.
                    if (DEB_ONE) begin
                        state_d      = PRESSED;
                        decr_pulse_d = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d      = PRESSED;
                    cnt_d        = '0;
                    decr_pulse_d = 1'b1;
                end
            end
            PRESSED, REPEAT: begin
                if (!s) begin
                    if (DEB_ONE) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_ONE;
                    end
                end else if (cnt_q == ((state_q == PRESSED) ? HOLD_LAST : REPEAT_LAST)) begin
                    state_d      = REPEAT;
                    cnt_d        = '0;
                    decr_pulse_d = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                // Re-press during release bounce returns to PRESSED without a new pulse.
                if (s) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase

        btn_state_d     = (state_d == PRESSED) || (state_d == REPEAT) || (state_d == RELEASE_WAIT);
        repeat_active_d = (state_d == REPEAT);
    end

    assign decr_pulse    = decr_pulse_q;
    assign btn_state     = btn_state_q;
    assign repeat_active = repeat_active_q;

endmodule
